// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pc_state_e;

    // Number of PC low bits that must be zero for a legal instruction address.
    function automatic int align_bits(input int align);
        return $clog2(align);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC helpers: sequential adder, trap-vector masking,
// jump-over-branch selection and the target alignment check.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ALIGN = 4
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic [XLEN-1:0] pc_plus_inc_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic            redir_o,
    output logic [XLEN-1:0] redir_target_o,
    output logic            redir_ok_o
);

    localparam int AB = align_bits(ALIGN);

    // Wraps modulo 2^XLEN through the natural width of the sum.
    assign pc_plus_inc_o  = pc_i + XLEN'(ALIGN);
    assign trap_pc_o      = {trap_vector_i[XLEN-1:AB], {AB{1'b0}}};
    assign redir_o        = jump_i | branch_taken_i;
    assign redir_target_o = jump_i ? jump_target_i : branch_target_i;
    assign redir_ok_o     = (redir_target_o[AB-1:0] == '0);

endmodule

// File: rtl/program_counter_unit.sv
// Program-counter unit: FSM, fetch-address register, fault capture and
// retired-advance counter around the pc_next_sel selection logic.
module program_counter_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              ALIGN        = 4,
    parameter int              CNT_W        = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             trap,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             halt,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus_inc,
    output logic             pc_valid,
    output logic             halted,
    output logic             misaligned,
    output logic [XLEN-1:0]  bad_target,
    output logic [CNT_W-1:0] instret
);

    if (ALIGN != 2 && ALIGN != 4) begin : g_bad_align
        $error("program_counter_unit: ALIGN must be 2 or 4");
    end

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  bad_q, bad_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             pc_valid_q, halted_q, misaligned_q;

    logic [XLEN-1:0]  trap_pc;
    logic             redir;
    logic [XLEN-1:0]  redir_target;
    logic             redir_ok;

    pc_next_sel #(
        .XLEN  (XLEN),
        .ALIGN (ALIGN)
    ) u_next_sel (
        .pc_i            (pc_q),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .trap_vector_i   (trap_vector),
        .pc_plus_inc_o   (pc_plus_inc),
        .trap_pc_o       (trap_pc),
        .redir_o         (redir),
        .redir_target_o  (redir_target),
        .redir_ok_o      (redir_ok)
    );

    // NOTE: every signal gets a hold default first so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        bad_d     = bad_q;
        instret_d = instret_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (trap) begin
                    pc_d = trap_pc;
                end else if (halt) begin
                    state_d = HALT;
                end else if (stall) begin
                    // Redirects arriving under stall are dropped; requester re-presents them.
                end else if (redir) begin
                    if (redir_ok) begin
                        pc_d      = redir_target;
                        instret_d = instret_q + CNT_W'(1);
                    end else begin
                        state_d = FAULT;
                        bad_d   = redir_target;
                    end
                end else begin
                    pc_d      = pc_plus_inc;
                    instret_d = instret_q + CNT_W'(1);
                end
            end
            HALT: begin
                if (trap) begin
                    state_d = RUN;
                    pc_d    = trap_pc;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                if (trap) begin
                    state_d = RUN;
                    pc_d    = trap_pc;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            bad_q        <= '0;
            instret_q    <= '0;
            pc_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            bad_q        <= bad_d;
            instret_q    <= instret_d;
            pc_valid_q   <= (state_d == RUN);
            halted_q     <= (state_d == HALT);
            misaligned_q <= (state_d == FAULT);
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign halted     = halted_q;
    assign misaligned = misaligned_q;
    assign bad_target = bad_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench: directed vector table, wrap/reset sequences and a
// randomized run against a behavioural model of the PC unit.
module tb_program_counter_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, branch_taken, jump, trap, halt, resume;
    logic [31:0] branch_target, jump_target, trap_vector;
    logic [31:0] pc, pc_plus_inc, bad_target;
    logic        pc_valid, halted, misaligned;
    logic [63:0] instret;

    logic        reset2;
    logic [7:0]  pc2, pc_plus_inc2, bad_target2;
    logic        pc_valid2, halted2, misaligned2;
    logic [3:0]  instret2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    program_counter_unit #(
        .XLEN(32), .RESET_VECTOR(32'h100), .ALIGN(4), .CNT_W(64)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .trap(trap), .trap_vector(trap_vector),
        .halt(halt), .resume(resume),
        .pc(pc), .pc_plus_inc(pc_plus_inc), .pc_valid(pc_valid),
        .halted(halted), .misaligned(misaligned),
        .bad_target(bad_target), .instret(instret)
    );

    program_counter_unit #(
        .XLEN(8), .RESET_VECTOR(8'hF0), .ALIGN(4), .CNT_W(4)
    ) dut_small (
        .clock(clock), .reset(reset2), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(8'h00),
        .jump(1'b0), .jump_target(8'h00),
        .trap(1'b0), .trap_vector(8'h00),
        .halt(1'b0), .resume(1'b0),
        .pc(pc2), .pc_plus_inc(pc_plus_inc2), .pc_valid(pc_valid2),
        .halted(halted2), .misaligned(misaligned2),
        .bad_target(bad_target2), .instret(instret2)
    );

    typedef struct {
        logic        stall, br, jmp, trap, halt, resume;
        logic [31:0] bt, jt, tv;
        logic [31:0] e_pc;
        logic        e_valid, e_halted, e_mis;
        logic [31:0] e_bad;
        logic [63:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic t, input logic [31:0] tv,
                                input logic h, input logic r,
                                input logic [31:0] e_pc, input logic e_valid,
                                input logic e_halted, input logic e_mis,
                                input logic [31:0] e_bad, input logic [63:0] e_inst);
        vec_t v;
        v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt;
        v.trap = t; v.tv = tv; v.halt = h; v.resume = r;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_halted = e_halted;
        v.e_mis = e_mis; v.e_bad = e_bad; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; jump = 0; trap = 0; halt = 0; resume = 0;
        branch_target = '0; jump_target = '0; trap_vector = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_halted, input logic e_mis,
                             input logic [31:0] e_bad, input logic [63:0] e_inst);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".pc_plus_inc"}, pc_plus_inc, e_pc + 32'd4);
        check({tag, ".pc_valid"}, pc_valid, e_valid);
        check({tag, ".halted"}, halted, e_halted);
        check({tag, ".misaligned"}, misaligned, e_mis);
        check({tag, ".bad_target"}, bad_target, e_bad);
        check({tag, ".instret"}, instret, e_inst);
    endtask

    // Behavioural model: mode flags plus architectural values.
    logic        m_boot, m_halt, m_fault;
    logic [31:0] m_pc, m_bad;
    logic [63:0] m_inst;

    task automatic model_step();
        logic [31:0] t;
        if (reset) begin
            m_boot = 1; m_halt = 0; m_fault = 0;
            m_pc = 32'h100; m_bad = 0; m_inst = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_fault) begin
            if (trap) begin m_pc = trap_vector & ~32'd3; m_fault = 0; end
        end else if (m_halt) begin
            if (trap) begin m_pc = trap_vector & ~32'd3; m_halt = 0; end
            else if (resume) m_halt = 0;
        end else if (trap) begin
            m_pc = trap_vector & ~32'd3;
        end else if (halt) begin
            m_halt = 1;
        end else if (stall) begin
            // frozen
        end else if (jump || branch_taken) begin
            t = jump ? jump_target : branch_target;
            if (t % 4 == 0) begin m_pc = t; m_inst = m_inst + 1; end
            else begin m_fault = 1; m_bad = t; end
        end else begin
            m_pc = m_pc + 32'd4;
            m_inst = m_inst + 1;
        end
    endtask

    initial begin
        logic [7:0] e2;
        logic [3:0] e2_inst;

        idle_inputs();
        reset = 1; reset2 = 1;
        tick(); tick();
        check_all("reset", 32'h100, 0, 0, 0, 0, 0);

        // stall br bt j jt trap tv halt resume | pc valid halted mis bad inst
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          0,0, 32'h100,     1,0,0, 0,       0));
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          0,0, 32'h104,     1,0,0, 0,       1));
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          0,0, 32'h108,     1,0,0, 0,       2));
        vecs.push_back(mk(0,1,32'h3000,   1,32'h2000,   0,0,          0,0, 32'h2000,    1,0,0, 0,       3));
        vecs.push_back(mk(1,0,0,          1,32'h5000,   0,0,          0,0, 32'h2000,    1,0,0, 0,       3));
        vecs.push_back(mk(1,0,0,          1,32'h5000,   0,0,          0,0, 32'h2000,    1,0,0, 0,       3));
        vecs.push_back(mk(1,1,32'h6000,   0,0,          0,0,          0,0, 32'h2000,    1,0,0, 0,       3));
        vecs.push_back(mk(0,1,32'h2002,   0,0,          0,0,          0,0, 32'h2000,    0,0,1, 32'h2002,3));
        vecs.push_back(mk(0,0,0,          1,32'h4000,   0,0,          0,1, 32'h2000,    0,0,1, 32'h2002,3));
        vecs.push_back(mk(0,0,0,          0,0,          1,32'h8003,   0,0, 32'h8000,    1,0,0, 32'h2002,3));
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          1,1, 32'h8000,    0,1,0, 32'h2002,3));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,      1,32'h9000,   0,0,          0,0, 32'h8000,    0,1,0, 32'h2002,3));
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          0,1, 32'h8000,    1,0,0, 32'h2002,3));
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          0,0, 32'h8004,    1,0,0, 32'h2002,4));
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          1,0, 32'h8004,    0,1,0, 32'h2002,4));
        vecs.push_back(mk(0,0,0,          0,0,          1,32'hA00F,   0,0, 32'hA00C,    1,0,0, 32'h2002,4));
        vecs.push_back(mk(1,0,0,          1,32'h7000,   1,32'h1237,   1,0, 32'h1234,    1,0,0, 32'h2002,4));
        vecs.push_back(mk(1,0,0,          0,0,          0,0,          1,0, 32'h1234,    0,1,0, 32'h2002,4));
        vecs.push_back(mk(0,0,0,          0,0,          0,0,          0,1, 32'h1234,    1,0,0, 32'h2002,4));
        vecs.push_back(mk(0,1,32'h1FFFFFFC,0,0,         0,0,          0,0, 32'h1FFFFFFC,1,0,0, 32'h2002,5));

        reset = 0;
        foreach (vecs[i]) begin
            stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            jump = vecs[i].jmp; jump_target = vecs[i].jt;
            trap = vecs[i].trap; trap_vector = vecs[i].tv;
            halt = vecs[i].halt; resume = vecs[i].resume;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_halted,
                      vecs[i].e_mis, vecs[i].e_bad, vecs[i].e_inst);
        end

        // Reset while in FAULT returns everything to the reset values.
        idle_inputs();
        branch_taken = 1; branch_target = 32'h11;
        tick();
        check("fault_entry.misaligned", misaligned, 1);
        idle_inputs();
        reset = 1;
        tick();
        check_all("reset_in_fault", 32'h100, 0, 0, 0, 0, 0);
        reset = 0;
        tick();
        check_all("boot_after_fault", 32'h100, 1, 0, 0, 0, 0);

        // 8-bit PC wrap past 0xFC and 4-bit counter wrap past 15.
        reset2 = 0;
        tick();
        check("small.boot_valid", pc_valid2, 1);
        check("small.boot_pc", pc2, 8'hF0);
        e2 = 8'hF0;
        e2_inst = 0;
        for (int i = 0; i < 16; i++) begin
            if (e2 == 8'hFC) check("small.plus_inc_wrap", pc_plus_inc2, 8'h00);
            tick();
            e2 = e2 + 8'd4;
            e2_inst = e2_inst + 4'd1;
            check($sformatf("small.pc%0d", i), pc2, e2);
            check($sformatf("small.instret%0d", i), instret2, e2_inst);
        end
        check("small.instret_wrapped", instret2, 0);

        // Randomized run against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = (i == 0) || ($urandom_range(0, 249) == 0);
            stall = ($urandom_range(0, 4) == 0);
            trap = ($urandom_range(0, 15) == 0);
            halt = ($urandom_range(0, 15) == 0);
            resume = ($urandom_range(0, 3) == 0);
            jump = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            jump_target = $urandom;
            branch_target = $urandom;
            trap_vector = $urandom;
            if ($urandom_range(0, 3) != 0) jump_target[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
            model_step();
            tick();
            check_all($sformatf("rand%0d", i), m_pc, !m_boot && !m_halt && !m_fault,
                      m_halt, m_fault, m_bad, m_inst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
